uart_rx_read_ctrl: RTL



---
 rtl/uart_rx_read_ctrl_pkg.sv | 17 +
 rtl/uart_sync_fifo.sv | 53 +++++
 rtl/uart_rx_read_ctrl.sv | 78 +++++++
 3 files changed

// File: rtl/uart_rx_read_ctrl_pkg.sv
// Shared UART definitions: the layout of a received-byte FIFO entry.
package uart_rx_read_ctrl_pkg;

  localparam int ENTRY_W  = 10;
  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = 7;
  localparam int PAR_BIT  = 8;
  localparam int STOP_BIT = 9;

  // Pack one received byte and its error flags into a FIFO entry.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [7:0] data,
                                                    input logic       par_err,
                                                    input logic       stop_err);
    return {stop_err, par_err, data};
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with a registered read port.
// The caller only issues wr_en/rd_en when they are legal; pushing into a
// full FIFO is allowed only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  output logic [W-1:0]      rd_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);

  localparam int CW = ADDR_W + 1;

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // Storage carries no reset; contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap by natural overflow; read data holds until the next pop.
  // A push into a full FIFO targets the slot being popped; the pop sees the
  // old contents because both sides are non-blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/uart_rx_read_ctrl.sv
// Host read controller for the UART Rx path: captures each completed byte
// (with parity/stop error flags) into a FIFO and hands it to the host on a
// single-cycle read strobe. Tracks a sticky overrun when bytes are dropped.
module uart_rx_read_ctrl
  import uart_rx_read_ctrl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      Rx_data,
  input  logic            Rx_rdy,
  input  logic            Rx_par_err,
  input  logic            Rx_stop_err,
  input  logic            Rd_en,
  input  logic            Clear_ovr,
  output logic [7:0]      Data_rd,
  output logic            Rd_valid,
  output logic            Rd_par_err,
  output logic            Rd_stop_err,
  output logic            FIFO_empty,
  output logic            FIFO_full,
  output logic [ADDR_W:0] Count,
  output logic            Overrun
);

  logic               rdy_q;
  logic               wr_evt;
  logic               rd_evt;
  logic               wr_accept;
  logic               ovr_set;
  logic [ENTRY_W-1:0] rd_entry;

  // Rx_rdy may stay high for several cycles; only its rising edge writes.
  assign wr_evt    = Rx_rdy & ~rdy_q;
  // Empty check uses the current state, so a write into an empty FIFO is
  // not readable in the same cycle.
  assign rd_evt    = Rd_en & ~FIFO_empty;
  // When full, a write is still taken if a pop frees a slot this cycle.
  assign wr_accept = wr_evt & (~FIFO_full | rd_evt);
  assign ovr_set   = wr_evt & FIFO_full & ~rd_evt;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_data (pack_entry(Rx_data, Rx_par_err, Rx_stop_err)),
    .rd_en   (rd_evt),
    .rd_data (rd_entry),
    .count   (Count),
    .empty   (FIFO_empty),
    .full    (FIFO_full)
  );

  assign Data_rd     = rd_entry[DATA_MSB:DATA_LSB];
  assign Rd_par_err  = rd_entry[PAR_BIT];
  assign Rd_stop_err = rd_entry[STOP_BIT];

  // Edge register, read-valid pulse and sticky overrun (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      Rd_valid <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      rdy_q    <= Rx_rdy;
      Rd_valid <= rd_evt;
      if (ovr_set)        Overrun <= 1'b1;
      else if (Clear_ovr) Overrun <= 1'b0;
    end
  end

endmodule
